// File: rtl/ap3_pipe_alu.sv
// Pipelined add/subtract/accumulate unit: the carry chain is cut into STAGES
// segments with a register between consecutive segments, valid/ready on both sides.
module ap3_pipe_alu #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4,
    parameter int ACC_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             bi,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] x,
    output logic             co,
    output logic             ov
);

    localparam int SEG = (WIDTH + STAGES - 1) / STAGES;
    localparam int PW  = $clog2(STAGES + 1) + 1;

    logic             adv;
    logic             accept;
    logic             acc_op;
    logic             is_load;
    logic             is_accum;
    logic             retire_acc;
    logic [WIDTH-1:0] acc;
    logic [PW-1:0]    acc_pend;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_c;
    logic             carry;

    // Pipeline registers: rX[k] is the output of stage k.
    logic [WIDTH-1:0] ra [STAGES];
    logic [WIDTH-1:0] rb [STAGES];
    logic [WIDTH-1:0] rs [STAGES];
    logic [WIDTH-1:0] rx [STAGES];
    logic [STAGES-1:0] rc, rm, rv, rf;

    // Stage inputs (previous register, or the operand mux for stage 0).
    logic [WIDTH-1:0] sa [STAGES];
    logic [WIDTH-1:0] sb [STAGES];
    logic [WIDTH-1:0] ss [STAGES];
    logic [WIDTH-1:0] sx [STAGES];
    logic [STAGES-1:0] sc, sm, sv, sf;

    // Next-state sum, carry-out and MSB carry-in of every stage.
    logic [WIDTH-1:0] ns [STAGES];
    logic [STAGES-1:0] nc, nm;

    assign acc_op   = (ACC_EN != 0) && op[1];
    assign is_load  = acc_op && op[0];
    assign is_accum = acc_op && !op[0];

    // A load is an add of a + 0 with no carry, so y = x = a and co = ov = 0.
    assign op_a = is_accum ? acc : a;
    assign op_b = is_load ? '0 : (bi ? ~b : b);
    assign op_c = is_load ? 1'b0 : ci;

    assign out_valid  = rv[STAGES-1];
    assign adv        = !out_valid || out_ready;
    assign in_ready   = rst_n && adv && !(in_valid && acc_op && (acc_pend != '0));
    assign accept     = in_valid && in_ready;
    assign retire_acc = out_valid && out_ready && rf[STAGES-1];

    assign y  = rs[STAGES-1];
    assign x  = rx[STAGES-1];
    assign co = rc[STAGES-1];
    assign ov = rm[STAGES-1] ^ rc[STAGES-1];

    for (genvar k = 0; k < STAGES; k++) begin : g_src
        if (k == 0) begin : g_first
            assign sa[k] = op_a;
            assign sb[k] = op_b;
            assign ss[k] = '0;
            assign sx[k] = op_a ^ op_b;
            assign sc[k] = op_c;
            assign sm[k] = 1'b0;
            assign sv[k] = accept;
            assign sf[k] = acc_op;
        end else begin : g_next
            assign sa[k] = ra[k-1];
            assign sb[k] = rb[k-1];
            assign ss[k] = rs[k-1];
            assign sx[k] = rx[k-1];
            assign sc[k] = rc[k-1];
            assign sm[k] = rm[k-1];
            assign sv[k] = rv[k-1];
            assign sf[k] = rf[k-1];
        end
    end

    // Stage k ripples only the bits of its own segment; a trailing empty
    // segment (possible with ceil sizing) just forwards the carry.
    always_comb begin
        carry = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            ns[k] = ss[k];
            nm[k] = sm[k];
            carry = sc[k];
            for (int i = 0; i < WIDTH; i++) begin
                if (i / SEG == k) begin
                    ns[k][i] = sa[k][i] ^ sb[k][i] ^ carry;
                    if (i == WIDTH - 1) begin
                        nm[k] = carry;
                    end
                    carry = (sa[k][i] & sb[k][i]) | (carry & (sa[k][i] ^ sb[k][i]));
                end
            end
            nc[k] = carry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rc <= '0;
            rm <= '0;
            rv <= '0;
            rf <= '0;
            for (int k = 0; k < STAGES; k++) begin
                ra[k] <= '0;
                rb[k] <= '0;
                rs[k] <= '0;
                rx[k] <= '0;
            end
        end else if (adv) begin
            rc <= nc;
            rm <= nm;
            rv <= sv;
            rf <= sf;
            for (int k = 0; k < STAGES; k++) begin
                ra[k] <= sa[k];
                rb[k] <= sb[k];
                rs[k] <= ns[k];
                rx[k] <= sx[k];
            end
        end
    end

    // Both load and accumulate retire their y into the accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            acc_pend <= '0;
        end else begin
            if (retire_acc) begin
                acc <= y;
            end
            case ({accept && acc_op, retire_acc})
                2'b10:   acc_pend <= acc_pend + PW'(1);
                2'b01:   acc_pend <= acc_pend - PW'(1);
                default: acc_pend <= acc_pend;
            endcase
        end
    end

endmodule

// File: tb/tb_ap3_pipe_alu.sv
// Scoreboard bench for ap3_pipe_alu at WIDTH=8, STAGES=2: expected results are
// queued at acceptance and compared when the DUT retires them.
module tb_ap3_pipe_alu;

    typedef struct packed {
        logic [7:0] y;
        logic [7:0] x;
        logic       co;
        logic       ov;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       ci = 1'b0;
    logic       bi = 1'b0;
    logic [1:0] op = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] y;
    logic [7:0] x;
    logic       co;
    logic       ov;

    int   checks = 0;
    int   fails = 0;
    int   retired = 0;
    exp_t sb[$];
    logic [7:0] model_acc = '0;

    ap3_pipe_alu #(.WIDTH(8), .STAGES(2), .ACC_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ci(ci), .bi(bi), .op(op),
        .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .x(x), .co(co), .ov(ov)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [7:0] a_v, input logic [7:0] b_v,
                                   input logic ci_v, input logic bi_v,
                                   input logic [1:0] op_v, input logic [7:0] acc_v);
        exp_t       e;
        logic [7:0] opa;
        logic [7:0] opb;
        logic [8:0] full;
        logic [7:0] low;
        if (op_v == 2'd3) begin
            e = '{y: a_v, x: a_v, co: 1'b0, ov: 1'b0};
        end else begin
            opa  = (op_v == 2'd2) ? acc_v : a_v;
            opb  = bi_v ? ~b_v : b_v;
            full = {1'b0, opa} + {1'b0, opb} + {8'd0, ci_v};
            low  = {1'b0, opa[6:0]} + {1'b0, opb[6:0]} + {7'd0, ci_v};
            e.y  = full[7:0];
            e.x  = opa ^ opb;
            e.co = full[8];
            e.ov = low[7] ^ full[8];
        end
        return e;
    endfunction

    // Retirement monitor: every handshaken result must match the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                checks++;
                retired++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("[TB] FAIL unexpected_result: got y=%h x=%h co=%b ov=%b, required no output",
                             y, x, co, ov);
                end else begin
                    e = sb.pop_front();
                    if ({y, x, co, ov} !== e) begin
                        fails++;
                        $display("[TB] FAIL result: got y=%h x=%h co=%b ov=%b, required y=%h x=%h co=%b ov=%b",
                                 y, x, co, ov, e.y, e.x, e.co, e.ov);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic send(input logic [7:0] a_v, input logic [7:0] b_v, input logic ci_v,
                        input logic bi_v, input logic [1:0] op_v, output int waited);
        exp_t e;
        waited = 0;
        @(posedge clk); #1;
        in_valid = 1'b1; a = a_v; b = b_v; ci = ci_v; bi = bi_v; op = op_v;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            fails++;
            $display("[TB] FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", in_ready, waited);
        end else begin
            e = model(a_v, b_v, ci_v, bi_v, op_v, model_acc);
            sb.push_back(e);
            if (op_v[1]) model_acc = e.y;
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0 || out_valid) begin
            fails++;
            $display("[TB] FAIL drain: %0d results outstanding, out_valid=%b, required 0 and 0",
                     sb.size(), out_valid);
        end
    endtask

    // Checks the two-cycle latency of a single op issued from an idle pipe.
    task automatic latency_op(input logic [7:0] a_v, input logic [7:0] b_v,
                              input logic ci_v, input logic bi_v);
        int w;
        send(a_v, b_v, ci_v, bi_v, 2'd0, w);
        idle();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL latency_early: out_valid=%b one cycle after accept, required 0", out_valid);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            fails++;
            $display("[TB] FAIL latency: out_valid=%b two cycles after accept, required 1", out_valid);
        end
        drain();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({out_valid, in_ready, y, x, co, ov} !== 20'd0) begin
            fails++;
            $display("[TB] FAIL reset_state: out_valid=%b in_ready=%b y=%h x=%h co=%b ov=%b, required all 0",
                     out_valid, in_ready, y, x, co, ov);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL ready_after_reset: in_ready=%b, required 1", in_ready);
        end
    endtask

    task automatic test_overflow();
        latency_op(8'h7F, 8'h01, 1'b0, 1'b0);
    endtask

    task automatic test_subtract();
        int w;
        send(8'h05, 8'h07, 1'b1, 1'b1, 2'd0, w);
        send(8'h07, 8'h05, 1'b1, 1'b1, 2'd0, w);
        idle();
        drain();
    endtask

    task automatic test_segment_carry();
        int w;
        send(8'h0F, 8'h01, 1'b0, 1'b0, 2'd0, w);
        send(8'hFF, 8'h01, 1'b0, 1'b0, 2'd0, w);
        send(8'hFF, 8'h00, 1'b1, 1'b0, 2'd0, w);
        send(8'h80, 8'h80, 1'b0, 1'b0, 2'd1, w);
        idle();
        drain();
    endtask

    task automatic test_backpressure();
        logic       pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [7:0] va  [6] = '{8'h12, 8'hF0, 8'h7F, 8'h33, 8'h80, 8'hAA};
        logic [7:0] vb  [6] = '{8'h34, 8'h20, 8'h7F, 8'h44, 8'h01, 8'h55};
        logic       vbi [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        int idx = 0;
        int cyc = 0;
        int start = retired;
        while (idx < 6 && cyc < 100) begin
            @(posedge clk); #1;
            out_ready = pat[cyc % 6];
            in_valid = 1'b1; a = va[idx]; b = vb[idx]; bi = vbi[idx]; ci = vbi[idx]; op = 2'd0;
            @(negedge clk);
            checks++;
            if (in_ready !== !(out_valid && !out_ready)) begin
                fails++;
                $display("[TB] FAIL bp_in_ready: in_ready=%b with out_valid=%b out_ready=%b, required %b",
                         in_ready, out_valid, out_ready, !(out_valid && !out_ready));
            end
            if (in_ready) begin
                sb.push_back(model(va[idx], vb[idx], vbi[idx], vbi[idx], 2'd0, model_acc));
                idx++;
            end
            cyc++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();
        checks++;
        if (retired - start != 6) begin
            fails++;
            $display("[TB] FAIL bp_count: %0d results retired, required 6", retired - start);
        end
    endtask

    task automatic test_accumulate();
        int w;
        send(8'h10, 8'h00, 1'b0, 1'b0, 2'd3, w);
        send(8'h00, 8'h20, 1'b0, 1'b0, 2'd2, w);
        checks++;
        if (w != 2) begin
            fails++;
            $display("[TB] FAIL acc_hazard1: op 2 blocked %0d cycles, required 2", w);
        end
        send(8'h01, 8'h02, 1'b0, 1'b0, 2'd0, w);
        checks++;
        if (w != 0) begin
            fails++;
            $display("[TB] FAIL op0_during_hazard: blocked %0d cycles, required 0", w);
        end
        send(8'h00, 8'h20, 1'b0, 1'b0, 2'd2, w);
        checks++;
        if (w != 1) begin
            fails++;
            $display("[TB] FAIL acc_hazard2: op 2 blocked %0d cycles, required 1", w);
        end
        idle();
        drain();
        checks++;
        if (dut.acc !== 8'h50) begin
            fails++;
            $display("[TB] FAIL acc_final: accumulator=%h, required 50", dut.acc);
        end
        send(8'h00, 8'h00, 1'b0, 1'b0, 2'd2, w);
        idle();
        drain();
    endtask

    task automatic test_reset_midflight();
        int w;
        send(8'h11, 8'h22, 1'b0, 1'b0, 2'd0, w);
        send(8'h33, 8'h44, 1'b0, 1'b0, 2'd0, w);
        @(posedge clk); #1;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || y !== 8'h00 || in_ready !== 1'b0) begin
            fails++;
            $display("[TB] FAIL midflight_reset: out_valid=%b y=%h in_ready=%b, required 0 00 0",
                     out_valid, y, in_ready);
        end
        sb.delete();
        model_acc = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                fails++;
                $display("[TB] FAIL stale_result: out_valid=%b cycle %0d after release, required 0", out_valid, i);
            end
        end
        latency_op(8'hC3, 8'h5A, 1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_overflow();
        test_subtract();
        test_segment_carry();
        test_backpressure();
        test_accumulate();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
